// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: word layout, opcode
// constants, instruction format enum, control state enum and the
// opcode-to-format decoder used by the field packer.
package instr_encoder_pkg;

  localparam int INSTR_W = 32;

  // Field widths
  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;
  localparam int MADDR_W = 8;

  // Field bit positions (LSB of each field in the 32-bit word)
  localparam int OPC_LSB     = 26;
  localparam int RD2_LSB     = 21;
  localparam int RD1_LSB     = 16;
  localparam int DST_LSB     = 18;
  localparam int RS2_ALU_LSB = 5;
  localparam int RS1_LSB     = 0;
  localparam int RS2_LSB     = 0;
  localparam int IMM_LSB     = 0;
  localparam int SRC_LSB     = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_LDI       = 6'h00;
  localparam logic [OPC_W-1:0] OP_MOV       = 6'h01;
  localparam logic [OPC_W-1:0] OP_LD        = 6'h02;
  localparam logic [OPC_W-1:0] OP_ST        = 6'h03;
  localparam logic [OPC_W-1:0] OP_ALU_FIRST = 6'h04;
  localparam logic [OPC_W-1:0] OP_ALU_LAST  = 6'h10;

  typedef enum logic [2:0] {
    FMT_IMM,
    FMT_MOV,
    FMT_LD,
    FMT_ST,
    FMT_ALU,
    FMT_ILLEGAL
  } fmt_e;

  typedef enum logic {
    ST_LOADING,
    ST_FULL
  } state_e;

  function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opc);
    fmt_e f;
    if (opc == OP_LDI)                                  f = FMT_IMM;
    else if (opc == OP_MOV)                             f = FMT_MOV;
    else if (opc == OP_LD)                              f = FMT_LD;
    else if (opc == OP_ST)                              f = FMT_ST;
    else if (opc >= OP_ALU_FIRST && opc <= OP_ALU_LAST) f = FMT_ALU;
    else                                                f = FMT_ILLEGAL;
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: purely combinational packer from instruction fields
// to a 32-bit instruction word.
//   opcode, rdst2, rdst1, rsrc2, rsrc1, imm, src_addr, dst_addr : fields in
//   word    : packed instruction (unused bit positions are 0)
//   illegal : opcode outside the defined range
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  input  logic [REG_W-1:0]   rdst2,
  input  logic [REG_W-1:0]   rdst1,
  input  logic [REG_W-1:0]   rsrc2,
  input  logic [REG_W-1:0]   rsrc1,
  input  logic [IMM_W-1:0]   imm,
  input  logic [MADDR_W-1:0] src_addr,
  input  logic [MADDR_W-1:0] dst_addr,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  fmt_e fmt;

  always_comb begin
    fmt     = decode_fmt(opcode);
    word    = '0;
    illegal = 1'b0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (fmt)
      FMT_IMM: begin
        word[RD2_LSB +: REG_W] = rdst2;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_MOV: begin
        word[RD2_LSB +: REG_W] = rdst2;
        word[RS2_LSB +: REG_W] = rsrc2;
      end
      FMT_LD: begin
        word[RD2_LSB +: REG_W]   = rdst2;
        word[SRC_LSB +: MADDR_W] = src_addr;
      end
      FMT_ST: begin
        word[DST_LSB +: MADDR_W] = dst_addr;
        word[RS2_LSB +: REG_W]   = rsrc2;
      end
      FMT_ALU: begin
        word[RD2_LSB +: REG_W]     = rdst2;
        word[RD1_LSB +: REG_W]     = rdst1;
        word[RS2_ALU_LSB +: REG_W] = rsrc2;
        word[RS1_LSB +: REG_W]     = rsrc1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction field bundles, packs them into 32-bit
// words and presents them with a sequential imem address to a writer.
//   clk, rst (sync, active-high), clear (sync restart of program load)
//   in_valid/in_ready + fields  : input bundle handshake
//   out_valid/out_ready, out_data, out_addr : encoded word to imem writer
//   full : DEPTH words accepted, err : sticky illegal-opcode flag
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_LOADING | accepting bundles, fewer than DEPTH words written
// ST_FULL    | DEPTH words accepted; waits for clear or rst
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REG_W-1:0]    rdst2,
  input  logic [REG_W-1:0]    rdst1,
  input  logic [REG_W-1:0]    rsrc2,
  input  logic [REG_W-1:0]    rsrc1,
  input  logic [IMM_W-1:0]    imm,
  input  logic [MADDR_W-1:0]  src_addr,
  input  logic [MADDR_W-1:0]  dst_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                full,
  output logic                err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [INSTR_W-1:0]  packed_word;
  logic                illegal;
  logic                accept;

  instr_field_pack u_pack (
    .opcode   (opcode),
    .rdst2    (rdst2),
    .rdst1    (rdst1),
    .rsrc2    (rsrc2),
    .rsrc1    (rsrc1),
    .imm      (imm),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .word     (packed_word),
    .illegal  (illegal)
  );

  assign full      = (state_q == ST_FULL);
  assign in_ready  = !rst && !full && !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A legal accept may coincide with the drain above; the new word then
    // replaces the old one on the same edge.
    if (accept && !illegal) begin
      out_valid_d = 1'b1;
      out_data_d  = packed_word;
      out_addr_d  = ptr_q;
      ptr_d       = ptr_q + ADDR_W'(1);
      count_d     = count_q + (ADDR_W+1)'(1);
      if (count_d == DEPTH_CNT) state_d = ST_FULL;
    end else if (accept && illegal) begin
      err_d = 1'b1;
    end

    if (clear) begin
      state_d     = ST_LOADING;
      out_valid_d = 1'b0;
      ptr_d       = '0;
      count_d     = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOADING;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
  logic [15:0] imm;
  logic [7:0]  src_addr, dst_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        full, err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  logic [39:0] sb_q[$];     // {addr, data}
  logic [7:0]  exp_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2), .rsrc1(rsrc1),
    .imm(imm), .src_addr(src_addr), .dst_addr(dst_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .full(full), .err(err)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd2, rd1, rs2, rs1,
                                      input logic [15:0] im, input logic [7:0] sa, da);
    logic [31:0] w;
    case (op)
      6'h00:   w = {op, rd2, 5'b0, im};
      6'h01:   w = {op, rd2, 16'b0, rs2};
      6'h02:   w = {op, rd2, 13'b0, sa};
      6'h03:   w = {op, da, 13'b0, rs2};
      default: w = {op, rd2, rd1, 6'b0, rs2, rs1};
    endcase
    return w;
  endfunction

  // Scoreboard: a word leaves the DUT when out_valid && out_ready at the
  // coming rising edge; sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [39:0] e;
      n_tests++;
      n_pops++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got addr=%h data=%h, expected no word", out_addr, out_data);
      end else begin
        e = sb_q.pop_front();
        if ({out_addr, out_data} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got addr=%h data=%h, expected addr=%h data=%h",
                   out_addr, out_data, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [4:0] rd2, rd1, rs2, rs1,
                      input logic [15:0] im, input logic [7:0] sa, da, output int waits);
    bit accepted = 0;
    opcode = op; rdst2 = rd2; rdst1 = rd1; rsrc2 = rs2; rsrc1 = rs1;
    imm = im; src_addr = sa; dst_addr = da;
    in_valid = 1'b1;
    waits = 0;
    while (!accepted && waits < 64) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        if (op <= 6'h10) begin
          sb_q.push_back({exp_addr, enc(op, rd2, rd1, rs2, rs1, im, sa, da)});
          exp_addr++;
        end
      end else waits++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL send_timeout: op=%h not accepted after %0d cycles, expected acceptance", op, waits);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 64) begin
      @(posedge clk); #1; w++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, out_data, out_addr, full, err, in_ready} !== 43'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h a=%h full=%b err=%b rdy=%b, expected all 0",
               out_valid, out_data, out_addr, full, err, in_ready);
    end
    rst = 1'b0;
    exp_addr = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_imm();
    int w;
    send(6'h00, 5'd3, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'h00, 8'h00, w);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h0060BEEF || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL imm_word: got v=%b d=%h a=%h, expected v=1 d=0060beef a=00",
               out_valid, out_data, out_addr);
    end
    drain();
  endtask

  task automatic test_alu_store();
    int w;
    send(6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 8'hFF, 8'hFF, w);
    n_tests++;
    if (out_data !== 32'h10220064 || out_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL alu_word: got d=%h a=%h, expected d=10220064 a=01", out_data, out_addr);
    end
    send(6'h03, 5'd31, 5'd31, 5'd7, 5'd31, 16'hFFFF, 8'hFF, 8'hA5, w);
    n_tests++;
    if (out_data !== 32'h0E940007 || out_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL store_word: got d=%h a=%h, expected d=0e940007 a=02", out_data, out_addr);
    end
    drain();
  endtask

  task automatic test_formats();
    int w;
    send(6'h01, 5'd9, 5'd31, 5'd17, 5'd31, 16'hFFFF, 8'hFF, 8'hFF, w);
    send(6'h02, 5'd30, 5'd31, 5'd31, 5'd31, 16'hFFFF, 8'h5A, 8'hFF, w);
    send(6'h10, 5'd31, 5'd0, 5'd31, 5'd0, 16'hFFFF, 8'hFF, 8'hFF, w);
    for (int i = 0; i < 8; i++) begin
      send(6'($urandom_range(0, 16)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 8'($urandom), 8'($urandom), w);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int stalls = 0;
    for (int i = 0; i < 6; i++) begin
      send(6'h05 + 6'(i), 5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, 8'h0, 8'h0, w);
      stalls += w;
    end
    n_tests++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d stall cycles, expected 0", stalls);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    int pops0;
    logic [31:0] exp_w;
    exp_w = enc(6'h07, 5'd11, 5'd12, 5'd13, 5'd14, 16'h0, 8'h0, 8'h0);
    out_ready = 1'b0;
    send(6'h07, 5'd11, 5'd12, 5'd13, 5'd14, 16'h0, 8'h0, 8'h0, w);
    pops0 = n_pops;
    in_valid = 1'b1;  // offered bundle must not be taken while stalled
    opcode = 6'h08;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_w || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b d=%h rdy=%b, expected v=1 d=%h rdy=0",
                 out_valid, out_data, in_ready, exp_w);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (n_pops - pops0 != 1 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_release: got %0d words out, %0d queued, expected 1 and 0",
               n_pops - pops0, sb_q.size());
    end
  endtask

  task automatic test_illegal();
    int w;
    logic [7:0] a0;
    a0 = exp_addr;
    send(6'h11, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 8'h1, 8'h1, w);
    n_tests++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_flag: got err=%b v=%b, expected err=1 v=0", err, out_valid);
    end
    send(6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 8'h1, 8'h1, w);
    send(6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h0, 8'h0, w);
    n_tests++;
    if (out_addr !== a0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_addr: got a=%h err=%b, expected a=%h err=1", out_addr, err, a0);
    end
    drain();
  endtask

  task automatic test_fill_clear();
    int w;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_addr = 8'h00;
    n_tests++;
    if (err !== 1'b0 || full !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: got err=%b full=%b v=%b, expected 0 0 0", err, full, out_valid);
    end
    for (int i = 0; i < 256; i++) begin
      send(6'h04 + 6'(i % 13), 5'(i), 5'(i >> 5), 5'(i + 7), 5'(i * 3), 16'h0, 8'h0, 8'h0, w);
      if (i == 254) begin
        n_tests++;
        if (full !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early: got full=%b after 255 words, expected 0", full);
        end
      end
    end
    n_tests++;
    if (full !== 1'b1 || in_ready !== 1'b0 || out_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL full_state: got full=%b rdy=%b a=%h, expected 1 0 ff", full, in_ready, out_addr);
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: got full=%b rdy=%b, expected 1 0", full, in_ready);
    end
    // clear wins over a simultaneous bundle
    clear = 1'b1;
    in_valid = 1'b1;
    opcode = 6'h00;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_override: got rdy=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    exp_addr = 8'h00;
    n_tests++;
    if (full !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_release: got full=%b v=%b, expected 0 0", full, out_valid);
    end
    send(6'h01, 5'd4, 5'd0, 5'd5, 5'd0, 16'h0, 8'h0, 8'h0, w);
    n_tests++;
    if (out_addr !== 8'h00 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_restart: got a=%h v=%b, expected a=00 v=1", out_addr, out_valid);
    end
    drain();
  endtask

  task automatic test_rst_mid();
    int w;
    send(6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 8'h0, 8'h0, w);
    out_ready = 1'b0;
    send(6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 16'hCAFE, 8'h0, 8'h0, w);
    n_tests++;
    if (out_valid !== 1'b1 || err !== 1'b1 || out_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL rst_setup: got v=%b err=%b a=%h, expected v=1 err=1 a=01", out_valid, err, out_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_addr !== 8'h00 || err !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b a=%h err=%b d=%h, expected 0 00 0 00000000",
               out_valid, out_addr, err, out_data);
    end
    rst = 1'b0;
    sb_q.delete();
    exp_addr = 8'h00;
    out_ready = 1'b1;
    send(6'h02, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0, 8'h33, 8'h0, w);
    drain();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; rdst2 = '0; rdst1 = '0; rsrc2 = '0; rsrc1 = '0;
    imm = '0; src_addr = '0; dst_addr = '0;
    exp_addr = 8'h00;
    test_reset();
    test_imm();
    test_alu_store();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_fill_clear();
    test_rst_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width.
REQ-002 SHALL have parameter DEPTH, default 256 (2**ADDR_W), meaning program capacity in words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous restart of program load.
REQ-006 SHALL have port in_valid  input  1  field bundle valid.
REQ-007 SHALL have port in_ready  output  1  bundle accepted when in_valid && in_ready.
REQ-008 SHALL have ports opcode  input  6, rdst2/rdst1/rsrc2/rsrc1  input  5 each, imm  input  16, src_addr/dst_addr  input  8 each: instruction fields.
REQ-009 SHALL have port out_valid  output  1  encoded word valid.
REQ-010 SHALL have port out_ready  input  1  sink (imem writer) accepts word.
REQ-011 SHALL have port out_data  output  32  encoded instruction word.
REQ-012 SHALL have port out_addr  output  ADDR_W  imem address of out_data.
REQ-013 SHALL have ports full  output  1, err  output  1 (sticky illegal-opcode flag).

Function
REQ-014 SHALL place opcode at [31:26]; all bits not assigned by the format SHALL be 0.
REQ-015 Opcode 0x00 (load-immediate) SHALL encode rdst2 at [25:21], imm at [15:0].
REQ-016 Opcode 0x01 (reg move) SHALL encode rdst2 at [25:21], rsrc2 at [4:0].
REQ-017 Opcode 0x02 (load) SHALL encode rdst2 at [25:21], src_addr at [7:0].
REQ-018 Opcode 0x03 (store) SHALL encode dst_addr at [25:18], rsrc2 at [4:0].
REQ-019 Opcodes 0x04-0x10 (ALU) SHALL encode rdst2 [25:21], rdst1 [20:16], rsrc2 [9:5], rsrc1 [4:0].
REQ-020 Opcodes 0x11-0x3F SHALL be illegal: bundle consumed, no word emitted, err set, address unchanged.
REQ-021 Single output register; latency 1 cycle from input handshake to out_valid.
REQ-022 in_ready = !full && !clear && (!out_valid || out_ready) (combinational).
REQ-023 out_valid/out_data/out_addr SHALL hold stable while out_valid && !out_ready.
REQ-024 Simultaneous output handshake and legal input handshake SHALL load the new word same edge (no bubble).
REQ-025 Write pointer (ADDR_W bits) SHALL advance by 1 per accepted legal bundle; out_addr = pointer value at acceptance.
REQ-026 Word counter (ADDR_W+1 bits) SHALL count accepted legal bundles; full=1 when count == DEPTH; no wrap.
REQ-027 While full, in_ready=0; a pending output word SHALL still drain.
REQ-028 clear SHALL zero pointer, count, full, err, and out_valid on the next edge; clear overrides a simultaneous input (not accepted).
REQ-029 Two-state control: LOADING (full=0) -> FULL on DEPTH-th acceptance; FULL -> LOADING only on clear or rst.

Reset
REQ-030 On rst: out_valid=0, out_data=0, out_addr=0, pointer=0, count=0, full=0, err=0, state LOADING.
REQ-031 rst SHALL take priority over clear and all handshakes; rst mid-transfer SHALL discard the pending word.
REQ-032 in_ready SHALL be 0 while rst is high.

Structure
REQ-033 Shared package SHALL hold opcode constants (0x00-0x10), field bit positions/widths, format enum (IMM, MOV, LD, ST, ALU, ILLEGAL), instruction width 32.
REQ-034 Combinational packer SHALL be a sub-module instr_field_pack (fields in -> 32-bit word + illegal flag); same package used by the decoder.

Verification
REQ-035 opcode=0x00, rdst2=3, imm=0xBEEF -> next cycle out_valid=1, out_data=0x0060BEEF, out_addr=0.
REQ-036 opcode=0x04, rdst2=1, rdst1=2, rsrc2=3, rsrc1=4 -> out_data=0x10220064; opcode=0x03, dst_addr=0xA5, rsrc2=7 -> out_data=0x0E940007.
REQ-037 out_ready=0 for 3 cycles with word pending -> out_data stable, in_ready=0, no word lost or duplicated after out_ready=1.
REQ-038 opcode=0x11 -> err=1, out_valid stays 0, next legal word out_addr unchanged.
REQ-039 256 legal bundles, out_ready=1 -> last out_addr=0xFF, full=1, in_ready=0; clear -> full=0, next out_addr=0x00.
REQ-040 rst asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_addr=0, err=0.
